// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   NUM_PORTS : number of requesters (fixed at 2)
//   MEM_WORDS : 32-bit words in the attached data memory
//   state_e   : arbiter FSM states
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int MEM_WORDS = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick.
//   valid      : per-port request valid
//   last_grant : index of the port granted most recently
//   grant      : one-hot winner (all zero when nothing is valid)
// A lone requester always wins; on a tie the port that was not granted
// last wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-cycle data memory.
// Every transaction walks IDLE -> ACCESS -> RESP.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-port request handshake (we, addr, wdata)
//   rsp_valid/rsp_ready   : per-port response handshake
//   rsp_rdata, rsp_err    : shared response payload
//   mem_*                 : memory port (mem_rd is combinational read data)
//   dbg_state             : current FSM state
// Handshake rule: a transfer happens on a rising edge where valid and
// ready are both high. Requesters may raise or drop req_valid freely;
// only the handshake cycle commits. Response data is held stable while
// rsp_valid is high and rsp_ready is low.
module dmem_arbiter #(
  parameter int NUM_PORTS = dmem_arb_pkg::NUM_PORTS,
  parameter int MEM_WORDS = dmem_arb_pkg::MEM_WORDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS-1:0]       req_valid,
  output logic [NUM_PORTS-1:0]       req_ready,
  input  logic [NUM_PORTS-1:0]       req_we,
  input  logic [NUM_PORTS-1:0][31:0] req_addr,
  input  logic [NUM_PORTS-1:0][31:0] req_wdata,
  output logic [NUM_PORTS-1:0]       rsp_valid,
  input  logic [NUM_PORTS-1:0]       rsp_ready,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_err,
  output logic [31:0]                mem_address,
  output logic [31:0]                mem_wd,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [31:0]                mem_rd,
  output logic [1:0]                 dbg_state
);

  import dmem_arb_pkg::*;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_e      state_q, state_d;
  logic        last_q, last_d;    // index of the last granted port
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  grant;
  logic        sel;
  logic        cmd_err;

  dmem_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  assign cmd_err   = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    sel         = grant[1];
    req_ready   = '0;
    rsp_valid   = '0;
    mem_address = '0;
    mem_wd      = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Gated by rst_n so every output is quiet while reset is held.
        req_ready = rst_n ? grant : '0;
        if (|grant) begin
          port_d  = sel;
          last_d  = sel;
          we_d    = req_we[sel];
          addr_d  = req_addr[sel];
          wdata_d = req_wdata[sel];
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_address = addr_q;
        mem_wd      = wdata_q;
        mem_read    = !we_q && !cmd_err;
        mem_write   = we_q && !cmd_err;
        rdata_d     = (!we_q && !cmd_err) ? mem_rd : 32'd0;
        err_d       = cmd_err;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid[port_q] = 1'b1;
        if (rsp_ready[port_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;  // port 0 wins the first tie
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter. A behavioural model
// (reference memory, round-robin last-winner, address-error rule) predicts
// grants and responses; outputs are sampled on the falling edge.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [31:0]      mem_address;
  logic [31:0]      mem_wd;
  logic             mem_read;
  logic             mem_write;
  logic [31:0]      mem_rd;
  logic [1:0]       dbg_state;

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_wd      (mem_wd),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rd      (mem_rd),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- attached memory ----------------
  logic [31:0] ext_mem [256];
  logic [31:0] ref_mem [256];

  function automatic logic [31:0] seed_val(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  assign mem_rd = ext_mem[mem_address[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) ext_mem[i] = seed_val(i);
    forever begin
      @(posedge clk);
      if (mem_write) ext_mem[mem_address[9:2]] = mem_wd;
    end
  end

  // ---------------- scoreboard / model ----------------
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  int          last_m;
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic        pend_we, pend_err;
  logic [31:0] pend_addr, pend_wdata;

  function automatic bit addr_bad(logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * MEM_WORDS));
  endfunction

  function automatic logic [31:0] onehot(int p);
    return 32'd1 << p;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0:       a = {22'd0, 8'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
      1:       a = 32'(1024 + 4 * $urandom_range(0, 255));
      default: a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
    endcase
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(int p, logic we, logic [31:0] addr, logic [31:0] wdata);
    req_we[p]    = we;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_ctl"}, 32'({req_ready, rsp_valid, mem_read, mem_write, rsp_err, dbg_state}), 32'd0);
    chk({tag, "_addr"}, mem_address, 32'd0);
    chk({tag, "_wd"}, mem_wd, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;  // must not leak to req_ready while in reset
    rsp_ready = 2'b00;
    @(negedge clk);
    check_quiet("rst");
    req_valid = 2'b00;
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
    exp_q.delete();
    exp_err_q.delete();
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge in ACCESS.
  task automatic issue(input logic [1:0] mask, output int w);
    logic        we, err;
    logic [31:0] addr, wdata;
    req_valid = mask;
    if (mask == 2'b01)      w = 0;
    else if (mask == 2'b10) w = 1;
    else                    w = (last_m == 0) ? 1 : 0;
    #1;
    chk("req_ready", 32'(req_ready), onehot(w));
    last_m = w;
    we     = req_we[w];
    addr   = req_addr[w];
    wdata  = req_wdata[w];
    err    = addr_bad(addr);
    exp_q.push_back((!we && !err) ? ref_mem[addr[9:2]] : 32'd0);
    exp_err_q.push_back(err);
    pend_we = we; pend_err = err; pend_addr = addr; pend_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    chk("acc_state", 32'(dbg_state), 32'(ST_ACCESS));
    chk("acc_req_ready", 32'(req_ready), 32'd0);
    chk("acc_mem_read", 32'(mem_read), 32'(!we && !err));
    chk("acc_mem_write", 32'(mem_write), 32'(we && !err));
    chk("acc_mem_address", mem_address, addr);
    chk("acc_mem_wd", mem_wd, wdata);
  endtask

  // Called on the ACCESS falling edge; returns on a falling edge in IDLE.
  task automatic respond(input int w, input int hold, input bit stray);
    logic [31:0] exp_rd;
    logic        exp_e;
    @(negedge clk);
    exp_rd = exp_q.pop_front();
    exp_e  = exp_err_q.pop_front();
    chk("rsp_valid", 32'(rsp_valid), onehot(w));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      if (stray) rsp_ready[1 - w] = 1'b1;
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), onehot(w));
      chk("hold_rsp_rdata", rsp_rdata, exp_rd);
      chk("hold_rsp_err", 32'(rsp_err), 32'(exp_e));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_mem_en", 32'({mem_read, mem_write}), 32'd0);
      chk("hold_state", 32'(dbg_state), 32'(ST_RESP));
    end
    rsp_ready = 2'(onehot(w));
    @(negedge clk);
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_state", 32'(dbg_state), 32'(ST_IDLE));
    if (pend_we && !pend_err) ref_mem[pend_addr[9:2]] = pend_wdata;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_val(i);
    req_we = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = '0; req_valid = '0; rst_n = 1'b0;
    do_reset();

    // write then read back on port 0
    set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    issue(2'b01, w); respond(w, 0, 1'b0);
    set_req(0, 1'b0, 32'h10, 32'h0);
    issue(2'b01, w); respond(w, 0, 1'b0);
    chk("readback_model", ref_mem[4], 32'hDEAD_BEEF);

    // tie-breaking alternates, starting with port 0 after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b0, {22'd0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
      set_req(1, 1'b0, {22'd0, 8'($urandom_range(0, 15)), 2'b00}, $urandom);
      issue(2'b11, w);
      chk("alt_grant", 32'(w), 32'(i % 2));
      respond(w, 0, 1'b0);
    end

    // misaligned and out-of-range reads on port 1
    set_req(1, 1'b0, 32'h402, 32'h0);
    issue(2'b10, w); respond(w, 1, 1'b0);
    set_req(1, 1'b0, 32'h400, 32'h0);
    issue(2'b10, w); respond(w, 1, 1'b0);

    // long response stall with the other port requesting
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 32'h30, 32'h1234_5678);
    issue(2'b11, w); respond(w, 5, 1'b0);

    // non-owning port asserts rsp_ready while port 1 owns the response
    set_req(1, 1'b0, 32'h30, 32'h0);
    issue(2'b10, w); respond(w, 3, 1'b1);

    // a request withdrawn before any clock edge is never granted
    req_valid = 2'b10;
    #1;
    chk("drop_ready", 32'(req_ready), 32'd2);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("drop_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset during ACCESS aborts a write
    set_req(0, 1'b1, 32'h20, 32'hCAFE_0001);
    issue(2'b01, w); respond(w, 0, 1'b0);
    set_req(0, 1'b1, 32'h20, 32'hBAD0_BAD0);
    issue(2'b01, w);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete(); exp_err_q.delete();
    req_valid = 2'b00;
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
    set_req(0, 1'b0, 32'h20, 32'h0);
    issue(2'b01, w); respond(w, 0, 1'b0);
    chk("abort_model", ref_mem[8], 32'hCAFE_0001);

    // reset during RESP discards the response
    set_req(1, 1'b0, 32'h24, 32'h0);
    issue(2'b10, w);
    @(negedge clk);
    chk("pre_abort_rsp_valid", 32'(rsp_valid), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.delete(); exp_err_q.delete();
    req_valid = 2'b00;
    @(negedge clk);
    rst_n  = 1'b1;
    last_m = 1;
    @(negedge clk);
    chk("post_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_abort_state", 32'(dbg_state), 32'(ST_IDLE));

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) set_req(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      issue(mask, w);
      respond(w, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
